// File: rtl/cbfp_index_buffer_if.sv
// Handshake bundle between the stage-0 CBFP normaliser, the index buffer and
// the downstream index-combining stage.
interface cbfp_index_buffer_if #(
   parameter int unsigned IDX_WIDTH = 5
) ();
   logic                 din_valid;
   logic [IDX_WIDTH-1:0] index_re_in;
   logic [IDX_WIDTH-1:0] index_im_in;
   logic                 idx_ready;
   logic                 idx_valid;
   logic [IDX_WIDTH-1:0] idx_re;
   logic [IDX_WIDTH-1:0] idx_im;

   modport master (
      output din_valid, index_re_in, index_im_in, idx_ready,
      input  idx_valid, idx_re, idx_im
   );

   modport slave (
      input  din_valid, index_re_in, index_im_in, idx_ready,
      output idx_valid, idx_re, idx_im
   );
endinterface

// File: rtl/cbfp_index_buffer.sv
// Captures one real/imag shift-index pair per 64-point block from the CBFP
// normaliser and queues it in a first-word-fall-through FIFO for later denormalisation.
module cbfp_index_buffer #(
   parameter int unsigned IDX_WIDTH       = 5,
   parameter int unsigned BEATS_PER_BLOCK = 4,
   parameter int unsigned DEPTH           = 8,
   parameter int unsigned PTR_WIDTH       = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   cbfp_index_buffer_if.slave     bus,
   input  logic                   flush,
   output logic [PTR_WIDTH:0]     count,
   output logic                   full,
   output logic                   overflow
);
   localparam int unsigned CNT_W  = PTR_WIDTH + 1;
   localparam int unsigned BEAT_W = (BEATS_PER_BLOCK > 1) ? $clog2(BEATS_PER_BLOCK) : 1;
   localparam int unsigned ENTRY_W = 2 * IDX_WIDTH;

   logic [BEAT_W-1:0]    beat_cnt;
   logic [PTR_WIDTH-1:0] wr_ptr;
   logic [PTR_WIDTH-1:0] rd_ptr;
   logic [CNT_W-1:0]     count_q;
   logic                 valid_q;
   logic                 full_q;
   logic                 overflow_q;
   logic [ENTRY_W-1:0]   mem [DEPTH];
   logic [ENTRY_W-1:0]   head;

   logic                 last_beat_c;
   logic                 pop_c;
   logic                 push_c;
   logic [CNT_W-1:0]     count_nxt_c;

   // A full FIFO still accepts a push when the same edge pops the head.
   always_comb begin
      last_beat_c = 1'b0;
      pop_c       = 1'b0;
      push_c      = 1'b0;
      count_nxt_c = count_q;
      last_beat_c = bus.din_valid && (beat_cnt == BEAT_W'(BEATS_PER_BLOCK - 1));
      pop_c       = valid_q && bus.idx_ready;
      push_c      = last_beat_c && (!full_q || pop_c);
      if (push_c && !pop_c) begin
         count_nxt_c = count_q + CNT_W'(1);
      end else if (pop_c && !push_c) begin
         count_nxt_c = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         beat_cnt   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (bus.din_valid) begin
            beat_cnt <= last_beat_c ? '0 : beat_cnt + BEAT_W'(1);
         end
         if (push_c) begin
            wr_ptr <= wr_ptr + PTR_WIDTH'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         end
         count_q <= count_nxt_c;
         valid_q <= (count_nxt_c != '0);
         full_q  <= (count_nxt_c == CNT_W'(DEPTH));
         if (last_beat_c && !push_c) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Storage needs no reset; stale entries are never presented while count is zero.
   always_ff @(posedge clk) begin
      if (push_c && !rst && !flush) begin
         mem[wr_ptr] <= {bus.index_re_in, bus.index_im_in};
      end
   end

   assign head          = mem[rd_ptr];
   assign bus.idx_valid = valid_q;
   assign bus.idx_re    = valid_q ? head[ENTRY_W-1:IDX_WIDTH] : '0;
   assign bus.idx_im    = valid_q ? head[IDX_WIDTH-1:0] : '0;
   assign count         = count_q;
   assign full          = full_q;
   assign overflow      = overflow_q;
endmodule

// File: tb/tb_cbfp_index_buffer.sv
// Directed bench for cbfp_index_buffer: queue scoreboard checked every cycle
// plus constant checks for each scenario.
module tb_cbfp_index_buffer;
   localparam int unsigned W     = 5;
   localparam int unsigned DEPTH = 8;

   typedef struct packed {
      logic [W-1:0] re;
      logic [W-1:0] im;
   } pair_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic [3:0] count;
   logic       full;
   logic       overflow;

   int checks   = 0;
   int failures = 0;

   pair_t sb[$];
   pair_t popped[$];
   int    m_beat = 0;
   bit    m_ovf  = 1'b0;

   cbfp_index_buffer_if #(.IDX_WIDTH(W)) bus ();

   cbfp_index_buffer #(
      .IDX_WIDTH(W), .BEATS_PER_BLOCK(4), .DEPTH(DEPTH), .PTR_WIDTH(3)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .flush(flush),
      .count(count), .full(full), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Compare all outputs against the scoreboard state.
   task automatic check_model();
      chk("m_count", 32'(count), 32'(sb.size()));
      chk("m_valid", 32'(bus.idx_valid), 32'(sb.size() != 0));
      chk("m_full", 32'(full), 32'(sb.size() == DEPTH));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_idx_re", 32'(bus.idx_re), (sb.size() != 0) ? 32'(sb[0].re) : 32'd0);
      chk("m_idx_im", 32'(bus.idx_im), (sb.size() != 0) ? 32'(sb[0].im) : 32'd0);
   endtask

   // One clock: check at negedge, drive inputs, update the scoreboard, then step past posedge.
   task automatic cyc(input logic dv, input logic [W-1:0] re, input logic [W-1:0] im,
                      input logic rdy, input logic fl, input logic rs);
      bit pop;
      @(negedge clk);
      check_model();
      bus.din_valid   = dv;
      bus.index_re_in = re;
      bus.index_im_in = im;
      bus.idx_ready   = rdy;
      flush           = fl;
      rst             = rs;
      if (rs || fl) begin
         sb.delete();
         m_beat = 0;
         m_ovf  = 1'b0;
      end else begin
         pop = (sb.size() != 0) && rdy;
         if (pop) popped.push_back(sb.pop_front());
         if (dv) begin
            if (m_beat == 3) begin
               if (sb.size() < DEPTH) sb.push_back(pair_t'({re, im}));
               else m_ovf = 1'b1;
               m_beat = 0;
            end else begin
               m_beat++;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, rdy, 1'b0, 1'b0);
   endtask

   task automatic block(input logic [W-1:0] re, input logic [W-1:0] im, input logic rdy);
      for (int b = 0; b < 3; b++) cyc(1'b1, 5'd31, 5'd31, rdy, 1'b0, 1'b0);
      cyc(1'b1, re, im, rdy, 1'b0, 1'b0);
   endtask

   task automatic expect_state(input string tag, input int v, input int re, input int im,
                               input int cnt);
      chk({tag, "_valid"}, 32'(bus.idx_valid), 32'(v));
      chk({tag, "_re"}, 32'(bus.idx_re), 32'(re));
      chk({tag, "_im"}, 32'(bus.idx_im), 32'(im));
      chk({tag, "_count"}, 32'(count), 32'(cnt));
   endtask

   initial begin
      bus.din_valid   = 1'b0;
      bus.index_re_in = '0;
      bus.index_im_in = '0;
      bus.idx_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      expect_state("reset", 0, 0, 0, 0);
      chk("reset_full", 32'(full), 32'd0);
      chk("reset_ovf", 32'(overflow), 32'd0);

      // Single block
      block(5'd7, 5'd3, 1'b0);
      expect_state("single", 1, 7, 3, 1);
      cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      expect_state("single_pop", 0, 0, 0, 0);

      // Gapped beats, 0..3 idle cycles between them
      cyc(1'b1, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b0);
      chk("gap_nopush", 32'(count), 32'd0);
      cyc(1'b1, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0);
      idle(3, 1'b0);
      chk("gap_nopush2", 32'(count), 32'd0);
      cyc(1'b1, 5'd12, 5'd21, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0);
      expect_state("gapped", 1, 12, 21, 1);
      idle(1, 1'b1);

      // Fill and overflow
      for (int k = 1; k <= 8; k++) block(W'(k), W'(31 - k), 1'b0);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_ovf_clear", 32'(overflow), 32'd0);
      block(5'd9, 5'd22, 1'b0);
      chk("fill_ovf", 32'(overflow), 32'd1);
      chk("fill_count", 32'(count), 32'd8);
      popped.delete();
      idle(9, 1'b1);
      chk("drain_n", 32'(popped.size()), 32'd8);
      for (int k = 0; k < popped.size(); k++) begin
         chk("drain_re", 32'(popped[k].re), 32'(k + 1));
         chk("drain_im", 32'(popped[k].im), 32'(30 - k));
      end
      chk("drain_ovf_sticky", 32'(overflow), 32'd1);
      chk("drain_empty", 32'(bus.idx_valid), 32'd0);

      // Push and pop together while full
      cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      chk("flush_ovf", 32'(overflow), 32'd0);
      for (int k = 1; k <= 8; k++) block(W'(k), W'(k), 1'b0);
      for (int b = 0; b < 3; b++) cyc(1'b1, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 5'd20, 5'd20, 1'b1, 1'b0, 1'b0);
      chk("pp_count", 32'(count), 32'd8);
      chk("pp_full", 32'(full), 32'd1);
      chk("pp_ovf", 32'(overflow), 32'd0);
      popped.delete();
      idle(9, 1'b1);
      chk("pp_n", 32'(popped.size()), 32'd8);
      for (int k = 0; k < popped.size(); k++)
         chk("pp_order", 32'(popped[k].re), (k == 7) ? 32'd20 : 32'(k + 2));

      // Flush then reset mid-block
      for (int pass = 0; pass < 2; pass++) begin
         block(5'd4, 5'd4, 1'b0);
         block(5'd5, 5'd5, 1'b0);
         block(5'd6, 5'd6, 1'b0);
         cyc(1'b1, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0);
         cyc(1'b1, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0);
         chk("mid_count3", 32'(count), 32'd3);
         cyc(1'b0, '0, '0, 1'b1, (pass == 0), (pass == 1));
         expect_state((pass == 0) ? "flush" : "rst", 0, 0, 0, 0);
         for (int b = 0; b < 3; b++) cyc(1'b1, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0);
         chk("fresh_nopush", 32'(count), 32'd0);
         cyc(1'b1, 5'd17, 5'd9, 1'b0, 1'b0, 1'b0);
         expect_state("fresh_push", 1, 17, 9, 1);
         idle(1, 1'b1);
      end

      // Streaming with continuous ready
      popped.delete();
      for (int b = 0; b < 16; b++) begin
         for (int t = 0; t < 4; t++) begin
            cyc(1'b1, (t == 3) ? W'(b + 3) : 5'd31, (t == 3) ? W'(28 - b) : 5'd31,
                1'b1, 1'b0, 1'b0);
            chk("stream_count_le1", 32'(count <= 4'd1), 32'd1);
         end
      end
      idle(2, 1'b1);
      chk("stream_n", 32'(popped.size()), 32'd16);
      for (int k = 0; k < popped.size(); k++) begin
         chk("stream_re", 32'(popped[k].re), 32'(k + 3));
         chk("stream_im", 32'(popped[k].im), 32'(28 - k));
      end
      chk("stream_ovf", 32'(overflow), 32'd0);
      idle(1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cbfp_index_buffer.md
Name: cbfp_index_buffer

Overview:
- Sits directly downstream of the stage-0 CBFP normaliser and consumes its valid strobe and its per-block real/imag shift indices.
- Counts 16-lane beats, captures one index pair per 64-point block (4 beats), and queues the pairs in a small FIFO.
- The later index-combining/denormalisation stage pops one pair per block with a valid/ready handshake, matching it to the data of that block arriving later in the pipeline.

Parameters:
- IDX_WIDTH, 5, width of each shift index (0..31)
- BEATS_PER_BLOCK, 4, valid beats of 16 samples per 64-point block
- DEPTH, 8, FIFO entries (power of two, >=2)
- PTR_WIDTH, $clog2(DEPTH), read/write pointer width

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- din_valid  input  1  beat strobe from the CBFP normaliser (one 16-lane beat per high cycle)
- index_re_in  input  IDX_WIDTH  real-part block shift index from the normaliser
- index_im_in  input  IDX_WIDTH  imag-part block shift index from the normaliser
- flush  input  1  synchronous clear of queue and beat counter
- idx_ready  input  1  downstream accepts head entry
- idx_valid  output  1  head entry available (FIFO not empty)
- idx_re  output  IDX_WIDTH  head real index
- idx_im  output  IDX_WIDTH  head imag index
- count  output  PTR_WIDTH+1  number of stored entries, 0..DEPTH
- full  output  1  count == DEPTH
- overflow  output  1  sticky, a push was dropped

Behaviour:
- Reset (rst=1 at a clock edge): beat_cnt=0, wr_ptr=rd_ptr=0, count=0, overflow=0. Outputs: idx_valid=0, idx_re=0, idx_im=0, full=0. Memory contents are don't-care. Reset mid-block discards the partial block; the next din_valid is beat 0.
- Beat counter:
  - Increments on each din_valid.
  - Wraps to 0 after BEATS_PER_BLOCK-1.
  - Holds when din_valid=0; gaps between beats are legal.
- Push: occurs on the cycle din_valid=1 and beat_cnt==BEATS_PER_BLOCK-1 (last beat of a block). Writes {index_re_in, index_im_in} sampled on that edge. Exactly one push per 4 valid beats.
- Pop: occurs when idx_valid && idx_ready at the edge. rd_ptr advances by 1.
- Pointers wrap modulo DEPTH.
- Head presentation: first-word fall-through.
  - idx_re/idx_im = mem[rd_ptr] whenever count>0; forced to 0 when empty.
  - idx_valid = (count!=0).
  - A push into an empty FIFO is visible the cycle after the push edge (1-cycle latency).
- Simultaneous push and pop:
  - Non-empty: both take effect, count unchanged.
  - Full: the pop frees the slot, so the push is accepted and overflow does not set.
  - Empty: only the push takes effect (idx_valid was 0, so no pop).
- Full, no pop: the push is dropped, overflow set to 1, count and memory unchanged, beat_cnt still wraps. overflow stays 1 until rst or flush.
- flush=1: same effect as reset on beat_cnt, pointers, count and overflow. It overrides a same-cycle push or pop. Outputs are idx_valid=0 and idx_re/idx_im=0 next cycle.
- idx_ready while empty has no effect. Pointers never move on an empty pop.
- All outputs are derived from registers; there is no combinational path from idx_ready to idx_valid.

Test Plan:
- Single block: 4 din_valid pulses, index_re_in=7 and index_im_in=3 on the 4th, idx_ready=0 -> next cycle idx_valid=1, idx_re=7, idx_im=3, count=1. Pulse idx_ready once -> idx_valid=0, idx_re=idx_im=0, count=0.
- Gapped beats: 4 valid pulses separated by 0-3 idle cycles, indices sampled only on the 4th pulse (other beats drive 31) -> exactly one entry, holding the 4th-beat values.
- Fill/overflow: 9 blocks with idx_ready=0, indices 1..9 -> full=1 after the 8th, overflow=1 after the 9th, count=8. Draining yields 1..8 in order; overflow stays 1.
- Push+pop at full: with the FIFO full, a block-end beat coincides with idx_ready=1 -> count stays 8, overflow=0, new entry appears last in drain order.
- Flush/reset mid-block: 2 valid beats, then flush=1 with 3 entries queued -> count=0, idx_valid=0. Next block needs 4 fresh beats before a push; repeat with rst=1 for identical results.
- Streaming: continuous din_valid with idx_ready=1 for 16 blocks, indices incrementing -> popped sequence equals pushed sequence, count never exceeds 1, overflow=0.
